mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Round-robin arbiter and sequencer that shares one pipelined signed 16x16 multiply-add datapath between `N_REQ` requesters. It computes `P = A*B + CARRYIN`. Each requester gets a valid/ready request port, and the block has a single response port carrying the requester ID. The block sits in front of the DSP-mapped multiplier, so several clients (filters, MAC loops) can time-share one hard multiplier without losing or reordering results.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: response ID width, equal to clog2(`N_REQ`).

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  reset, synchronous, active-low; clock `CLK`.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_ready`  out  `N_REQ`  per-requester accept, one-hot or zero.
- `req_a`  in  `N_REQ*16`  signed A operands; requester i occupies slice [16i+15:16i].
- `req_b`  in  `N_REQ*16`  signed B operands, same packing as `req_a`.
- `req_cin`  in  `N_REQ`  carry-in bit per requester.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  downstream accepts the result.
- `rsp_id`  out  `ID_W`  index of the requester that owns `rsp_p`.
- `rsp_p`  out  32  signed result.

## Operation
- **Transfer rule.** A request transfers when `req_valid[i] & req_ready[i]`. A response transfers when `rsp_valid & rsp_ready`.
- **Stall.** `stall = rsp_valid & ~rsp_ready`. While stalled:
  - every pipeline register holds its value;
  - `req_ready` is all-zero;
  - the round-robin pointer is frozen.
- **Arbitration (not stalled).**
  - Grant goes to the first asserted `req_valid` found by searching from `rr_ptr` upward, wrapping from `N_REQ-1` to 0.
  - `req_ready` is the one-hot grant. It is combinational from `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
  - After a grant to requester k, `rr_ptr` becomes (k+1) mod `N_REQ`.
  - With no valid request, no grant is made and `rr_ptr` is unchanged.
- **Stage 1 register.** Holds `prod = signed(A)*signed(B)` (32-bit), the cin bit, the ID, and `v1`.
- **Stage 2 register.** Holds `rsp_p = prod + zero-extended cin` (32-bit, wraps modulo 2^32), plus the ID and `rsp_valid`.
- **Flow.** Bubbles advance when not stalled. Stage 2 never holds a stale result: when not stalled, `rsp_valid` loads `v1`.
- **Ordering.** Responses leave in grant order; there is no reordering.
- **Reset (RST=0 at a CLK edge).**
  - `v1`, `rsp_valid`, `rsp_p`, `rsp_id`, the stage 1 data and `rr_ptr` all clear to 0.
  - `req_ready` = 0 during and after the reset cycle, until `RST` is sampled high.
  - In-flight operations are discarded and no response is issued for them.
- **Simultaneous events.**
  - A grant and a response handshake in the same cycle are allowed; the pipeline advances.
  - If all requesters are valid continuously, each receives one grant every `N_REQ` cycles.

## Timing
- Latency: grant at edge t puts the result on `rsp_valid`/`rsp_p` after edge t+2.
- Throughput: 1 op/cycle when `rsp_ready` = 1.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, `rsp_valid` and `rsp_ready`.
- All other outputs are registered.
- Backpressure reaches the requesters in the same cycle; nothing is dropped.

## Configuration
- Macro `MULT_SHARE_FIXED_PRIO_EN`.
  - **Defined:** fixed priority, lowest index wins. `rr_ptr` is not implemented and is tied to 0.
  - **Undefined (default):** round-robin as described in Operation.
- The pipeline, handshake and arithmetic are identical in both builds.

## Structure
- Package `mult_share_pkg`:
  - `OP_W = 16`, `P_W = 32`;
  - typedef `op_t` = signed [15:0], `prod_t` = signed [31:0];
  - a stage-1 struct {valid, id, cin, prod}.
- Sub-module `rr_arbiter`: parameterised `N_REQ` input, produces the one-hot grant and next pointer, and handles the fixed-priority macro internally.
- Top level: stall logic and the two pipeline stages, written as a single module so DSP inference stays intact.

## Test plan
- **Single op.**
  - Stimulus: requester 2, `a` = -32768, `b` = -32768, `cin` = 1.
  - Response two cycles after the grant: `rsp_p` = 0x40000001, `rsp_id` = 2.
- **Sign and wrap.**
  - Stimulus: requester 0, `a` = 32767, `b` = -32768, `cin` = 0.
  - Response: `rsp_p` = 0xC0008000.
- **Fairness.**
  - Stimulus: all 4 requesters held valid for 8 cycles, `rsp_ready` = 1.
  - Response: grant order 0,1,2,3,0,1,2,3.
  - With `MULT_SHARE_FIXED_PRIO_EN` defined: all 8 grants go to requester 0.
- **Backpressure.**
  - Stimulus: `rsp_ready` = 0 for 5 cycles with a stream in flight.
  - Response: `rsp_p`/`rsp_id` stable, `req_ready` = 0, and after release no result is lost or duplicated.
- **Reset mid-operation.**
  - Stimulus: `RST` = 0 for one cycle with 2 ops in flight.
  - Response: `rsp_valid` = 0 and `rsp_p` = 0 next cycle, neither op is ever returned, and the next grant goes to requester 0.
- **Idle gap.**
  - Stimulus: alternate 1 request and 2 idle cycles on requester 3.
  - Response: `rsp_valid` is a single-cycle pulse each time, with exactly 2-cycle latency.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types for the time-shared signed 16x16 multiply-add datapath.
package mult_share_pkg;

    localparam int OP_W     = 16;
    localparam int P_W      = 32;
    localparam int ID_MAX_W = 3;

    typedef logic signed [OP_W-1:0] op_t;
    typedef logic signed [P_W-1:0]  prod_t;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic                cin;
        prod_t               prod;
    } stage1_t;

endpackage

// File: rtl/mult_share_arb_rr_arbiter.sv
// One-hot grant and next-pointer generation for the shared multiplier.
// MULT_SHARE_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic [ID_W-1:0]  ptr_nxt
);

`ifdef MULT_SHARE_FIXED_PRIO_EN
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        ptr_nxt = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt       = '0;
                gnt[i]    = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
    end
`else
    logic found;

    // Search offsets from ptr upward; the inner index stays constant per unrolled term.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + off) % N_REQ)) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_id  = ID_W'(i);
                    ptr_nxt = ID_W'((i + 1) % N_REQ);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/mult_share_arb.sv
// Arbitrates N_REQ requesters onto one two-stage signed P = A*B + CARRYIN pipeline.
// Build option: MULT_SHARE_FIXED_PRIO_EN (fixed priority, handled inside rr_arbiter).
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*16-1:0] req_a,
    input  logic [N_REQ*16-1:0] req_b,
    input  logic [N_REQ-1:0]    req_cin,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [31:0]         rsp_p
);

    function automatic prod_t add_cin(prod_t p, logic c);
        return p + prod_t'({{(P_W-1){1'b0}}, c});
    endfunction

    logic             stall;
    logic             open;
    logic             fire;
    logic             rst_q;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  ptr_nxt;
    op_t              a_p0;
    op_t              b_p0;
    logic             cin_p0;
    stage1_t          st_p1;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .ptr_nxt (ptr_nxt)
    );

    // rst_q keeps requesters blocked until RST has been sampled high once.
    assign stall     = rsp_valid & ~rsp_ready;
    assign open      = ~stall & RST & rst_q;
    assign req_ready = open ? gnt : '0;
    assign fire      = |req_ready;

    always_ff @(posedge CLK) begin
        rst_q <= RST;
        if (!RST)
            rr_ptr <= '0;
        else if (fire)
            rr_ptr <= ptr_nxt;
    end

    always_comb begin
        a_p0   = '0;
        b_p0   = '0;
        cin_p0 = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                a_p0   = op_t'(req_a[16*i +: 16]);
                b_p0   = op_t'(req_b[16*i +: 16]);
                cin_p0 = req_cin[i];
            end
        end
    end

    // ---- stage 1: signed product ----
    always_ff @(posedge CLK) begin
        if (!RST) begin
            st_p1 <= '0;
        end else if (!stall) begin
            st_p1.valid <= fire;
            st_p1.id    <= ID_MAX_W'(gnt_id);
            st_p1.cin   <= cin_p0;
            st_p1.prod  <= prod_t'(a_p0) * prod_t'(b_p0);
        end
    end

    // ---- stage 2: carry-in add, response register ----
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else if (!stall) begin
            rsp_valid <= st_p1.valid;
            rsp_id    <= ID_W'(st_p1.id);
            rsp_p     <= add_cin(st_p1.prod, st_p1.cin);
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed plan steps plus randomized traffic vs a queue model.
module tb_mult_share_arb;

    logic        CLK;
    logic        RST;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_p;

    mult_share_arb #(.N_REQ(4), .ID_W(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        int          id;
        logic [31:0] p;
    } rsp_t;

    // Reference model: ops in flight in grant order, plus latency occupancy bits.
    rsp_t sb[$];
    int   grant_log[$];
    int   m_ptr   = 0;
    bit   m_v1    = 0;
    bit   m_v2    = 0;
    bit   m_live  = 0;
    bit   m_known = 0;

    logic signed [15:0] op_a [4];
    logic signed [15:0] op_b [4];
    logic               op_c [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
            op_c[i] = 1'($urandom);
        end
    endtask

    function automatic logic [31:0] exp_p(int g);
        int r;
        r = int'(op_a[g]) * int'(op_b[g]) + (op_c[g] ? 1 : 0);
        return 32'(r);
    endfunction

    function automatic int model_grant(logic [3:0] v, logic rr, logic rst_n);
        if (!rst_n || !m_live || (m_v2 && !rr))
            return -1;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (v[idx])
                return idx;
        end
        return -1;
    endfunction

    task automatic step(input logic rst_n, input logic [3:0] v, input logic rr);
        int         g;
        logic [3:0] er;
        RST       = rst_n;
        req_valid = v;
        rsp_ready = rr;
        req_a     = {op_a[3], op_a[2], op_a[1], op_a[0]};
        req_b     = {op_b[3], op_b[2], op_b[1], op_b[0]};
        req_cin   = {op_c[3], op_c[2], op_c[1], op_c[0]};
        @(negedge CLK);
        g = model_grant(v, rr, rst_n);
        if (m_known) begin
            er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            check("req_ready", {28'd0, req_ready}, {28'd0, er});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_v2});
            if (m_v2 && rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    check("rsp_id", {30'd0, rsp_id}, 32'(sb[0].id));
                    check("rsp_p", rsp_p, sb[0].p);
                end
            end
        end
        for (int k = 0; k < 4; k++)
            if (req_ready[k]) grant_log.push_back(k);
        @(posedge CLK);
        if (!rst_n) begin
            m_v1 = 0; m_v2 = 0; m_ptr = 0; m_live = 0; m_known = 1;
            sb.delete();
        end else begin
            if (m_known) begin
                if (m_v2 && rr && sb.size() > 0)
                    void'(sb.pop_front());
                if (!(m_v2 && !rr)) begin
                    m_v2 = m_v1;
                    m_v1 = (g >= 0);
                    if (g >= 0) begin
                        sb.push_back('{g, exp_p(g)});
`ifndef MULT_SHARE_FIXED_PRIO_EN
                        m_ptr = (g + 1) % 4;
`endif
                    end
                end
            end
            m_live = 1;
        end
        #1;
    endtask

    logic [31:0] held_p;
    logic [1:0]  held_id;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rand_ops();
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_p", rsp_p, 32'd0);
        check("reset_req_ready", {28'd0, req_ready}, 32'd0);
        step(1'b1, 4'b0000, 1'b1);

        // Single op with most-negative operands on requester 2.
        rand_ops();
        op_a[2] = -16'sd32768; op_b[2] = -16'sd32768; op_c[2] = 1'b1;
        step(1'b1, 4'b0100, 1'b1);
        check("single_lat1", {31'd0, rsp_valid}, 32'd0);
        step(1'b1, 4'b0000, 1'b1);
        check("single_valid", {31'd0, rsp_valid}, 32'd1);
        check("single_p", rsp_p, 32'h4000_0001);
        check("single_id", {30'd0, rsp_id}, 32'd2);
        step(1'b1, 4'b0000, 1'b1);
        check("single_pulse", {31'd0, rsp_valid}, 32'd0);

        // Sign and wrap on requester 0.
        op_a[0] = 16'sd32767; op_b[0] = -16'sd32768; op_c[0] = 1'b0;
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        check("wrap_valid", {31'd0, rsp_valid}, 32'd1);
        check("wrap_p", rsp_p, 32'hC000_8000);
        check("wrap_id", {30'd0, rsp_id}, 32'd0);
        step(1'b1, 4'b0000, 1'b1);

        // Fairness from a freshly reset pointer.
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        grant_log.delete();
        for (int c = 0; c < 8; c++) begin
            rand_ops();
            step(1'b1, 4'b1111, 1'b1);
        end
        check("fair_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < grant_log.size()) begin
`ifdef MULT_SHARE_FIXED_PRIO_EN
                check("fair_order", 32'(grant_log[k]), 32'd0);
`else
                check("fair_order", 32'(grant_log[k]), 32'(k % 4));
`endif
            end
        end

        // Backpressure with a full pipeline.
        held_p  = rsp_p;
        held_id = rsp_id;
        for (int c = 0; c < 5; c++) begin
            rand_ops();
            step(1'b1, 4'b1111, 1'b0);
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_p_stable", rsp_p, held_p);
            check("bp_id_stable", {30'd0, rsp_id}, {30'd0, held_id});
        end
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            step(1'b1, 4'b1111, 1'b1);
        end
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        // Reset with two ops in flight.
        rand_ops();
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        step(1'b0, 4'b1111, 1'b1);
        check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_p", rsp_p, 32'd0);
        grant_log.delete();
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        check("rst_gnt_count", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0)
            check("rst_first_gnt", 32'(grant_log[0]), 32'd0);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        // Idle gaps on requester 3.
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            step(1'b1, 4'b1000, 1'b1);
            check("gap_lat1", {31'd0, rsp_valid}, 32'd0);
            step(1'b1, 4'b0000, 1'b1);
            check("gap_valid", {31'd0, rsp_valid}, 32'd1);
            check("gap_id", {30'd0, rsp_id}, 32'd3);
            step(1'b1, 4'b0000, 1'b1);
            check("gap_pulse", {31'd0, rsp_valid}, 32'd0);
        end

        // Randomized traffic with backpressure and occasional reset.
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            step(($urandom_range(0, 99) != 0), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 4; c++)
            step(1'b1, 4'b0000, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
